// File: rtl/color_sample_sequencer.sv
// Round-robin multi-channel colour sensor sequencer.
// Averages 2^AVG_LOG2 RGB samples per channel, with timeout and error flags.
module color_sample_sequencer #(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 2000000
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            enable,
  input  logic            measure,
  input  logic            continuous,
  output logic [NCH-1:0]  sns_start,
  input  logic [NCH-1:0]  sns_ready,
  input  logic [NCH*DW-1:0] sns_red,
  input  logic [NCH*DW-1:0] sns_green,
  input  logic [NCH*DW-1:0] sns_blue,
  output logic [NCH*DW-1:0] avg_red,
  output logic [NCH*DW-1:0] avg_green,
  output logic [NCH*DW-1:0] avg_blue,
  output logic [NCH-1:0]  avg_valid,
  output logic [NCH-1:0]  err,
  output logic            busy,
  output logic            done
);

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] SLAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CLAST = CW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACCUM,
    S_TMO,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, nstate;

  logic [CW-1:0] ch;
  logic [SW-1:0] smp;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] acc_r, acc_g, acc_b;
  logic [DW-1:0] avg_r [NCH];
  logic [DW-1:0] avg_g [NCH];
  logic [DW-1:0] avg_b [NCH];

  logic [DW-1:0] sel_r, sel_g, sel_b;
  logic          hit;
  logic          last_smp;

  assign last_smp = (smp == SLAST);
  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  always_comb begin
    sel_r = '0;
    sel_g = '0;
    sel_b = '0;
    hit = 1'b0;
    sns_start = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == CW'(k)) begin
        sel_r = sns_red[k*DW +: DW];
        sel_g = sns_green[k*DW +: DW];
        sel_b = sns_blue[k*DW +: DW];
        hit = sns_ready[k];
        sns_start[k] = (state == S_START);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= nstate;
  end

  // Ready seen on the final timeout cycle still wins over the timeout.
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (measure || continuous) nstate = S_START;
      S_START: nstate = S_WAIT;
      S_WAIT: begin
        if (hit)                nstate = S_ACCUM;
        else if (tcnt == TLAST) nstate = S_TMO;
      end
      S_ACCUM: nstate = last_smp ? S_NEXT : S_START;
      S_TMO:   nstate = S_NEXT;
      S_NEXT:  nstate = (ch == CLAST) ? S_DONE : S_START;
      S_DONE:  nstate = continuous ? S_START : S_IDLE;
      default: nstate = S_IDLE;
    endcase
    if (!enable) nstate = S_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ch <= '0;
      smp <= '0;
      tcnt <= '0;
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
      avg_valid <= '0;
      err <= '0;
      for (int k = 0; k < NCH; k++) begin
        avg_r[k] <= '0;
        avg_g[k] <= '0;
        avg_b[k] <= '0;
      end
    end else begin
      avg_valid <= '0;
      if (!enable) begin
        ch <= '0;
        smp <= '0;
        acc_r <= '0;
        acc_g <= '0;
        acc_b <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            ch <= '0;
            smp <= '0;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
          end
          S_START: tcnt <= '0;
          S_WAIT: begin
            tcnt <= tcnt + TW'(1);
            if (hit) begin
              acc_r <= acc_r + AW'(sel_r);
              acc_g <= acc_g + AW'(sel_g);
              acc_b <= acc_b + AW'(sel_b);
            end
          end
          S_ACCUM: begin
            if (!last_smp) begin
              smp <= smp + SW'(1);
            end else begin
              for (int k = 0; k < NCH; k++) begin
                if (ch == CW'(k)) begin
                  avg_r[k] <= acc_r[AW-1:AVG_LOG2];
                  avg_g[k] <= acc_g[AW-1:AVG_LOG2];
                  avg_b[k] <= acc_b[AW-1:AVG_LOG2];
                  avg_valid[k] <= 1'b1;
                  err[k] <= 1'b0;
                end
              end
            end
          end
          S_TMO: begin
            for (int k = 0; k < NCH; k++) begin
              if (ch == CW'(k)) err[k] <= 1'b1;
            end
          end
          S_NEXT: begin
            smp <= '0;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            if (ch != CLAST) ch <= ch + CW'(1);
          end
          S_DONE: ch <= '0;
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign avg_red[k*DW +: DW]   = avg_r[k];
    assign avg_green[k*DW +: DW] = avg_g[k];
    assign avg_blue[k*DW +: DW]  = avg_b[k];
  end

endmodule

// File: tb/tb_color_sample_sequencer.sv
// Bench for color_sample_sequencer: random sensor replies vs averaging model.
// Sensor responder, cycle monitor and a linear directed/random test sequence.
module tb_color_sample_sequencer;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int NS  = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic nrst, enable, measure, continuous;
  logic [NCH-1:0] sns_start, sns_ready, avg_valid, err;
  logic [NCH*DW-1:0] sns_red, sns_green, sns_blue;
  logic [NCH*DW-1:0] avg_red, avg_green, avg_blue;
  logic busy, done;

  color_sample_sequencer #(
    .NCH(NCH), .DW(DW), .AVG_LOG2(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable),
    .measure(measure), .continuous(continuous),
    .sns_start(sns_start), .sns_ready(sns_ready),
    .sns_red(sns_red), .sns_green(sns_green), .sns_blue(sns_blue),
    .avg_red(avg_red), .avg_green(avg_green), .avg_blue(avg_blue),
    .avg_valid(avg_valid), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int dly [NCH];
  logic spur = 1'b0;
  logic [DW-1:0] sr [NCH][NS];
  logic [DW-1:0] sg [NCH][NS];
  logic [DW-1:0] sb [NCH][NS];

  logic [DW-1:0] er [NCH];
  logic [DW-1:0] eg [NCH];
  logic [DW-1:0] eb [NCH];
  logic [NCH-1:0] eerr = '0;
  int eok [NCH];

  int cyc = 0, starts = 0, done_cnt = 0;
  int done_cyc = 0, sweep_cyc = 0;
  int av_cnt [NCH] = '{default: 0};
  logic prev_busy = 1'b0;
  logic multi = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (nrst === 1'b1) begin
      if (sns_start != '0) starts++;
      if (!$onehot0(sns_start)) multi = 1'b1;
      if (sns_start[0] && !prev_busy) sweep_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      for (int k = 0; k < NCH; k++)
        if (avg_valid[k]) av_cnt[k]++;
    end
    prev_busy = busy;
  end

  // Sensor front-end: ready dly[k] cycles after its start pulse.
  int cd [NCH] = '{default: 0};
  int idx [NCH] = '{default: 0};
  int active = 0;
  initial begin
    sns_ready = '0;
    sns_red = '0;
    sns_green = '0;
    sns_blue = '0;
    forever begin
      @(posedge clk);
      #1;
      sns_ready = '0;
      for (int k = 0; k < NCH; k++) begin
        sns_red[k*DW +: DW] = DW'($urandom);
        sns_green[k*DW +: DW] = DW'($urandom);
        sns_blue[k*DW +: DW] = DW'($urandom);
      end
      if (nrst !== 1'b1) begin
        for (int k = 0; k < NCH; k++) begin
          cd[k] = 0;
          idx[k] = 0;
        end
      end else begin
        if (!busy)
          for (int k = 0; k < NCH; k++) idx[k] = 0;
        for (int k = 0; k < NCH; k++) begin
          if (cd[k] > 0) begin
            cd[k]--;
            if (cd[k] == 0) begin
              sns_ready[k] = 1'b1;
              sns_red[k*DW +: DW] = sr[k][idx[k] % NS];
              sns_green[k*DW +: DW] = sg[k][idx[k] % NS];
              sns_blue[k*DW +: DW] = sb[k][idx[k] % NS];
              idx[k]++;
            end
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (sns_start[k]) begin
            active = k;
            if (dly[k] > 0) cd[k] = dly[k];
          end
        end
        if (spur)
          for (int k = 0; k < NCH; k++)
            if (k != active && cd[k] == 0 && !sns_ready[k])
              sns_ready[k] = 1'($urandom);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget,
                           input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  // Channel succeeds iff its sensor replies within TMO cycles;
  // average is the truncated mean of its NS samples.
  task automatic model_sweep(output int es);
    es = 0;
    for (int k = 0; k < NCH; k++) begin
      int sum_r = 0, sum_g = 0, sum_b = 0;
      eok[k] = (dly[k] >= 1 && dly[k] <= TMO) ? 1 : 0;
      if (eok[k] == 1) begin
        for (int i = 0; i < NS; i++) begin
          sum_r += int'(sr[k][i]);
          sum_g += int'(sg[k][i]);
          sum_b += int'(sb[k][i]);
        end
        er[k] = DW'(sum_r / NS);
        eg[k] = DW'(sum_g / NS);
        eb[k] = DW'(sum_b / NS);
        eerr[k] = 1'b0;
        es += NS;
      end else begin
        eerr[k] = 1'b1;
        es += 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < NCH; k++) begin
      chk({tag, "_avg_r"}, 64'(avg_red[k*DW +: DW]), 64'(er[k]));
      chk({tag, "_avg_g"}, 64'(avg_green[k*DW +: DW]), 64'(eg[k]));
      chk({tag, "_avg_b"}, 64'(avg_blue[k*DW +: DW]), 64'(eb[k]));
    end
    chk({tag, "_err"}, 64'(err), 64'(eerr));
  endtask

  task automatic randomize_samples();
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < NS; i++) begin
        sr[k][i] = DW'($urandom);
        sg[k][i] = DW'($urandom);
        sb[k][i] = DW'($urandom);
      end
  endtask

  task automatic run_sweep(input string tag, input bit extra);
    int s0, d0, es;
    int a0 [NCH];
    s0 = starts;
    d0 = done_cnt;
    a0 = av_cnt;
    measure = 1'b1;
    step(1);
    measure = 1'b0;
    if (extra) begin
      step(30);
      measure = 1'b1;
      step(1);
      measure = 1'b0;
    end
    wait_done(d0 + 1, 3000, {tag, "_timeout"});
    step(3);
    model_sweep(es);
    @(negedge clk);
    chk({tag, "_starts"}, 64'(starts - s0), 64'(es));
    chk({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    for (int k = 0; k < NCH; k++)
      chk({tag, "_avg_valid"}, 64'(av_cnt[k] - a0[k]), 64'(eok[k]));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    check_state(tag);
  endtask

  initial begin
    int s0, d0, n;
    int a0 [NCH];
    nrst = 1'b0;
    enable = 1'b0;
    measure = 1'b0;
    continuous = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      dly[k] = 10;
      er[k] = '0;
      eg[k] = '0;
      eb[k] = '0;
    end
    randomize_samples();

    step(3);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(sns_start), 64'd0);
    chk("rst_valid", 64'(avg_valid), 64'd0);
    check_state("rst");

    step(1);
    nrst = 1'b1;
    enable = 1'b1;
    step(2);

    for (int i = 0; i < NS; i++) sr[0][i] = DW'(100 + i);
    run_sweep("basic", 1'b1);
    chk("basic_red0", 64'(avg_red[DW-1:0]), 64'd101);
    chk("basic_latency", 64'(done_cyc - sweep_cyc), 64'd98);

    randomize_samples();
    dly[0] = TMO;
    dly[1] = 0;
    run_sweep("tmo", 1'b0);

    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < NS; i++) begin
        sr[k][i] = '1;
        sg[k][i] = '1;
        sb[k][i] = '1;
      end
    dly[0] = 7;
    dly[1] = 12;
    run_sweep("max", 1'b0);
    chk("max_red1", 64'(avg_red[2*DW-1:DW]), 64'hFFFF);

    for (int it = 0; it < 6; it++) begin
      randomize_samples();
      for (int k = 0; k < NCH; k++) begin
        n = int'($urandom_range(0, 9));
        if (n == 0)      dly[k] = 0;
        else if (n == 1) dly[k] = TMO;
        else if (n == 2) dly[k] = TMO + 1;
        else             dly[k] = int'($urandom_range(1, 20));
      end
      spur = 1'($urandom);
      run_sweep("rand", 1'b0);
    end
    spur = 1'b0;

    randomize_samples();
    dly[0] = 3;
    dly[1] = 3;
    d0 = done_cnt;
    continuous = 1'b1;
    wait_done(d0 + 1, 500, "cont_first");
    step(3);
    chk("cont_restart", 64'(sweep_cyc - done_cyc), 64'd1);
    @(negedge clk);
    chk("cont_busy", 64'(busy), 64'd1);
    continuous = 1'b0;
    wait_done(d0 + 2, 500, "cont_second");
    s0 = starts;
    step(20);
    @(negedge clk);
    chk("cont_idle", 64'(busy), 64'd0);
    chk("cont_dones", 64'(done_cnt - d0), 64'd2);
    chk("cont_nostart", 64'(starts - s0), 64'd0);
    model_sweep(n);
    check_state("cont");

    randomize_samples();
    dly[0] = 5;
    dly[1] = 5;
    s0 = starts;
    d0 = done_cnt;
    a0 = av_cnt;
    measure = 1'b1;
    step(1);
    measure = 1'b0;
    n = 0;
    while (starts - s0 < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach", 64'(starts - s0), 64'd3);
    step(2);
    enable = 1'b0;
    step(1);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    step(100);
    enable = 1'b1;
    step(5);
    @(negedge clk);
    chk("abort_nodone", 64'(done_cnt - d0), 64'd0);
    chk("abort_novalid", 64'(av_cnt[0] - a0[0]), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    check_state("abort");

    measure = 1'b1;
    step(1);
    measure = 1'b0;
    step(3);
    #2;
    nrst = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) begin
      er[k] = '0;
      eg[k] = '0;
      eb[k] = '0;
    end
    eerr = '0;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_start", 64'(sns_start), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    check_state("arst");
    step(2);
    nrst = 1'b1;
    step(2);

    randomize_samples();
    dly[0] = int'($urandom_range(1, 20));
    dly[1] = int'($urandom_range(1, 20));
    run_sweep("after_rst", 1'b0);
    chk("onehot_start", 64'(multi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
